// File: rtl/traffic_phase_sched_if.sv
// Junction sequencer bus: run enable and car/emergency requests in, light state out.
// Latency: none (wires only); the scheduler registers every output.
// Backpressure: none; en is the only throttle and freezes the scheduler.
interface traffic_phase_sched_if;
    logic       en;
    logic [3:0] car_req;
    logic       emerg_req;
    logic [1:0] emerg_dir;
    logic [1:0] traffic_light;
    logic [1:0] phase;
    logic       green_valid;
    logic       dir_change;
    logic       emerg_active;

    // Request side (bench / upstream sensors)
    modport master (
        output en, car_req, emerg_req, emerg_dir,
        input  traffic_light, phase, green_valid, dir_change, emerg_active
    );

    // Scheduler side
    modport slave (
        input  en, car_req, emerg_req, emerg_dir,
        output traffic_light, phase, green_valid, dir_change, emerg_active
    );
endinterface

// File: rtl/traffic_phase_sched.sv
// 4-way junction phase sequencer: GREEN -> YELLOW -> ALL_RED per direction, round robin over waiting cars.
// Latency: all outputs registered; decisions take effect on the edge that samples the inputs.
// Backpressure: en=0 freezes every register (dir_change forced 0). Optional EMERG_PREEMPT_EN adds emergency preemption.
module traffic_phase_sched #(
    parameter int GREEN_MIN = 5,
    parameter int GREEN_MAX = 20,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 1,
    parameter int CNT_W     = 8
) (
    input logic                  clk,
    input logic                  rst_n,
    traffic_phase_sched_if.slave bus
);

    typedef enum logic [1:0] {
        GREEN   = 2'd0,
        YELLOW  = 2'd1,
        ALL_RED = 2'd2
    } phase_e;

    localparam logic [CNT_W-1:0] GMIN_LAST = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] GMAX_LAST = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] YEL_LAST  = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] ARED_LAST = CNT_W'(ALLRED_T - 1);

    phase_e           phase_q, phase_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [1:0]       tl_q, tl_d;
    logic             dc_q, dc_d;
    logic             ea_q, ea_d;
    logic             gv_q, gv_d;

    logic [3:0]       cur_onehot;
    logic             other_req;
    logic             cur_req;
    logic [1:0]       rr_dir;
    logic [1:0]       grant_dir;
    logic [1:0]       cand;
    logic             found;
    logic             emerg_on;
    logic             emerg_other;

    assign cur_onehot = 4'b0001 << tl_q;
    assign other_req  = |(bus.car_req & ~cur_onehot);
    assign cur_req    = bus.car_req[tl_q];

`ifdef EMERG_PREEMPT_EN
    assign emerg_on    = bus.emerg_req;
    assign emerg_other = bus.emerg_req && (bus.emerg_dir != tl_q);
    assign grant_dir   = bus.emerg_req ? bus.emerg_dir : rr_dir;
`else
    // Emergency inputs are accepted but have no effect in this build.
    logic emerg_unused;
    assign emerg_unused = ^{bus.emerg_req, bus.emerg_dir};
    assign emerg_on     = 1'b0;
    assign emerg_other  = 1'b0;
    assign grant_dir    = rr_dir;
`endif

    // Round robin: first waiting direction after the current one, wrapping back to it; cur+1 if nobody waits.
    always_comb begin
        rr_dir = tl_q + 2'd1;
        found  = 1'b0;
        cand   = tl_q;
        for (int k = 1; k <= 4; k++) begin
            cand = tl_q + 2'(k);
            if (!found && bus.car_req[cand]) begin
                rr_dir = cand;
                found  = 1'b1;
            end
        end
    end

    // Next-state: phase sequencing, phase timer, direction grant and pulse/flag outputs.
    always_comb begin
        phase_d = phase_q;
        timer_d = timer_q;
        tl_d    = tl_q;
        dc_d    = 1'b0;
        ea_d    = ea_q;
        if (bus.en) begin
            unique case (phase_q)
                GREEN: begin
                    // An emergency for the current direction pins green; one elsewhere cuts it short.
                    if (emerg_other ||
                        (!emerg_on && other_req &&
                         ((timer_q >= GMIN_LAST && !cur_req) || timer_q == GMAX_LAST))) begin
                        phase_d = YELLOW;
                        timer_d = '0;
                        if (emerg_other) ea_d = 1'b1;
                    end else if (timer_q < GMAX_LAST) begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                YELLOW: begin
                    if (emerg_on) ea_d = 1'b1;
                    if (timer_q == YEL_LAST) begin
                        phase_d = ALL_RED;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                ALL_RED: begin
                    if (timer_q == ARED_LAST) begin
                        phase_d = GREEN;
                        timer_d = '0;
                        tl_d    = grant_dir;
                        dc_d    = 1'b1;
                        ea_d    = emerg_on;
                    end else begin
                        timer_d = timer_q + 1'b1;
                        if (emerg_on) ea_d = 1'b1;
                    end
                end
                default: begin
                    phase_d = ALL_RED;
                    timer_d = '0;
                end
            endcase
        end
        gv_d = (phase_d == GREEN);
    end

    // State register with synchronous active-low reset into a fresh ALL_RED.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q <= ALL_RED;
            timer_q <= '0;
            tl_q    <= 2'd3;
            dc_q    <= 1'b0;
            ea_q    <= 1'b0;
            gv_q    <= 1'b0;
        end else begin
            phase_q <= phase_d;
            timer_q <= timer_d;
            tl_q    <= tl_d;
            dc_q    <= dc_d;
            ea_q    <= ea_d;
            gv_q    <= gv_d;
        end
    end

    assign bus.traffic_light = tl_q;
    assign bus.phase         = phase_q;
    assign bus.green_valid   = gv_q;
    assign bus.dir_change    = dc_q;
    assign bus.emerg_active  = ea_q;

endmodule

// File: tb/tb_traffic_phase_sched.sv
// Bench for the junction sequencer: directed scenarios then random traffic.
// A phase-level reference model pushes expected outputs on each edge; a negedge monitor pops and compares.
// Optional EMERG_PREEMPT_EN is mirrored in the model.
module tb_traffic_phase_sched;
    localparam int GREEN_MIN = 5;
    localparam int GREEN_MAX = 20;
    localparam int YELLOW_T  = 3;
    localparam int ALLRED_T  = 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    traffic_phase_sched_if bus();

    traffic_phase_sched #(
        .GREEN_MIN(GREEN_MIN), .GREEN_MAX(GREEN_MAX),
        .YELLOW_T(YELLOW_T), .ALLRED_T(ALLRED_T), .CNT_W(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    typedef struct {
        int tl;
        int ph;
        bit gv;
        bit dc;
        bit ea;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: phase name, which direction is lit, how many cycles already spent in this phase.
    int m_ph = 2;
    int m_tl = 3;
    int m_el = 0;
    bit m_dc = 0;
    bit m_ea = 0;
    bit m_others;
    bit m_go;

    function automatic int pick_next(int cur, logic [3:0] car);
        for (int k = 1; k <= 4; k++)
            if (car[(cur + k) % 4]) return (cur + k) % 4;
        return (cur + 1) % 4;
    endfunction

    always @(posedge clk) begin
        exp_t e;
        if (!rst_n) begin
            m_ph = 2; m_tl = 3; m_el = 0; m_dc = 0; m_ea = 0;
        end else if (!bus.en) begin
            m_dc = 0;
        end else begin
            m_dc = 0;
            if (m_ph == 0) begin
                m_others = 0;
                for (int i = 0; i < 4; i++)
                    if (i != m_tl && bus.car_req[i]) m_others = 1;
                m_go = m_others && ((m_el + 1 >= GREEN_MIN && !bus.car_req[m_tl]) ||
                                    m_el + 1 >= GREEN_MAX);
`ifdef EMERG_PREEMPT_EN
                if (bus.emerg_req) begin
                    m_go = (int'(bus.emerg_dir) != m_tl);
                    if (m_go) m_ea = 1;
                end
`endif
                if (m_go) begin m_ph = 1; m_el = 0; end
                else m_el++;
            end else if (m_ph == 1) begin
`ifdef EMERG_PREEMPT_EN
                if (bus.emerg_req) m_ea = 1;
`endif
                if (m_el + 1 == YELLOW_T) begin m_ph = 2; m_el = 0; end
                else m_el++;
            end else begin
                if (m_el + 1 == ALLRED_T) begin
                    m_ph = 0; m_el = 0; m_dc = 1;
                    m_tl = pick_next(m_tl, bus.car_req);
`ifdef EMERG_PREEMPT_EN
                    if (bus.emerg_req) m_tl = int'(bus.emerg_dir);
                    m_ea = bus.emerg_req;
`endif
                end else begin
                    m_el++;
`ifdef EMERG_PREEMPT_EN
                    if (bus.emerg_req) m_ea = 1;
`endif
                end
            end
        end
        e.tl = m_tl; e.ph = m_ph; e.gv = (m_ph == 0); e.dc = m_dc; e.ea = m_ea;
        sb_q.push_back(e);
    end

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Monitor: compares the registered outputs mid-cycle against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("traffic_light", int'(bus.traffic_light), e.tl);
            check("phase",         int'(bus.phase),         e.ph);
            check("green_valid",   int'(bus.green_valid),   int'(e.gv));
            check("dir_change",    int'(bus.dir_change),    int'(e.dc));
            check("emerg_active",  int'(bus.emerg_active),  int'(e.ea));
        end
    end

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_state(int ph, int tl, int budget, string name);
        int i;
        i = 0;
        while (!(m_ph == ph && (tl < 0 || m_tl == tl)) && i < budget) begin
            step(1);
            i++;
        end
        checks++;
        if (!(m_ph == ph && (tl < 0 || m_tl == tl))) begin
            errors++;
            $display("FAIL wait_%s: model phase %0d tl %0d, wanted phase %0d tl %0d", name, m_ph, m_tl, ph, tl);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.en = 1'b1;
        bus.car_req = 4'b0000;
        bus.emerg_req = 1'b0;
        bus.emerg_dir = 2'd0;
        step(2);
        rst_n = 1'b1;

        // Idle junction: one ALL_RED cycle, then direction 0 green and held.
        step(101);

        // Lone request at 2: minimum green then yellow/all-red into direction 2.
        bus.car_req = 4'b0100;
        wait_state(0, 2, 30, "dir2");
        bus.car_req = 4'b0001;
        wait_state(0, 0, 30, "dir0");
        step(3);

        // Current direction stays busy: green runs to the maximum, then direction 1.
        bus.car_req = 4'b0011;
        wait_state(0, 1, 40, "dir1_max");
        bus.car_req = 4'b1000;
        wait_state(0, 3, 30, "dir3");

        // Skip over direction 0; freeze four cycles in the middle of yellow.
        bus.car_req = 4'b0010;
        wait_state(1, -1, 30, "yellow");
        step(1);
        bus.en = 1'b0;
        step(4);
        bus.en = 1'b1;
        wait_state(0, 1, 30, "dir1_skip");

        // Emergency toward direction 2 while direction 0 is green at t=2.
        bus.car_req = 4'b0001;
        wait_state(0, 0, 30, "dir0_emerg");
        step(2);
        bus.emerg_dir = 2'd2;
        bus.emerg_req = 1'b1;
        step(15);
        bus.emerg_req = 1'b0;
        step(30);

        // Reset pulse for one edge during green of direction 2.
        bus.car_req = 4'b0100;
        wait_state(0, 2, 60, "dir2_rst");
        step(2);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(5);

        // Random traffic, enables, emergencies and rare resets.
        for (int c = 0; c < 4000; c++) begin
            bus.en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 7) == 0) bus.car_req = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 29) == 0) bus.emerg_req = ~bus.emerg_req;
            if ($urandom_range(0, 9) == 0) bus.emerg_dir = 2'($urandom_range(0, 3));
            rst_n = ($urandom_range(0, 599) != 0);
            step(1);
        end
        rst_n = 1'b1;
        step(3);
        @(negedge clk);
        #1;
        check("scoreboard_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
